// File: rtl/route_grant_sequencer_pkg.sv
// Shared types for the route output stages: port vector, class width and
// the grant sequencer state encoding.
package route_pkg;
  localparam int NPORT_DEF = 4;
  localparam int CLS_W     = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_HOLD} rgs_state_t;
  typedef logic [NPORT_DEF-1:0] port_vec_t;
endpackage

// File: rtl/route_grant_sequencer_if.sv
// Decision, beat and grant signals between route-decision logic, the grant
// sequencer and the output ports.
interface route_grant_sequencer_if
  import route_pkg::*;
#(
  parameter int NPORT = NPORT_DEF
);
  logic             dec_valid;
  logic             dec_ready;
  logic [NPORT-1:0] dec_req;
  logic [CLS_W-1:0] dec_cls;
  logic             beat_valid;
  logic             beat_last;
  logic             beat_ready;
  logic [NPORT-1:0] port_ready;
  logic [NPORT-1:0] grant;
  logic [CLS_W-1:0] grant_cls;
  logic             timeout_evt;

  modport slave (
    input  dec_valid, dec_req, dec_cls, beat_valid, beat_last, port_ready,
    output dec_ready, beat_ready, grant, grant_cls, timeout_evt
  );

  modport master (
    output dec_valid, dec_req, dec_cls, beat_valid, beat_last, port_ready,
    input  dec_ready, beat_ready, grant, grant_cls, timeout_evt
  );
endinterface

// File: rtl/route_grant_sequencer_rr_pick.sv
// Rotating priority encoder: first set request at or above i_ptr, wrapping.
// Purely combinational so other output stages can share it.
module route_grant_sequencer_rr_pick #(
  parameter  int NPORT = 4,
  localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NPORT-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = '0;
    for (int k = 0; k < NPORT; k++) begin
      w_pos = IDX_W'((int'(i_ptr) + k) % NPORT);
      if (!o_any && i_req[w_pos]) begin
        o_any           = 1'b1;
        o_idx           = w_pos;
        o_onehot[w_pos] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/route_grant_sequencer.sv
// Registers a route decision, grants one output port round-robin and holds it
// until the tail beat or a stall timeout.
module route_grant_sequencer
  import route_pkg::*;
#(
  parameter int NPORT  = NPORT_DEF,
  parameter int TO_W   = 8,
  parameter int TO_MAX = 200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  route_grant_sequencer_if.slave bus
);
  localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  rgs_state_t       r_state, w_state_nxt;
  logic [NPORT-1:0] r_req;
  logic [CLS_W-1:0] r_cls;
  logic [NPORT-1:0] r_grant;
  logic [CLS_W-1:0] r_grant_cls;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_started;

  logic             w_dec_rdy, w_dec_acc, w_beat_rdy, w_beat_acc, w_to_hit;
  logic [NPORT-1:0] w_pick_oh;
  logic [IDX_W-1:0] w_pick_idx, w_ptr_nxt;
  logic             w_pick_any;

  route_grant_sequencer_rr_pick #(.NPORT(NPORT)) u_pick (
    .i_req    (r_req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // r_started keeps dec_ready low until the first edge after reset release
  assign w_dec_rdy  = (r_state == ST_IDLE) && r_started;
  assign w_dec_acc  = bus.dec_valid && w_dec_rdy;
  assign w_beat_rdy = (r_state == ST_HOLD) && |(bus.port_ready & r_grant);
  assign w_beat_acc = bus.beat_valid && w_beat_rdy;
  assign w_ptr_nxt  = (w_pick_idx == IDX_W'(NPORT-1)) ? '0 : w_pick_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_to_hit    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_dec_acc && |bus.dec_req) w_state_nxt = ST_ARB;
      ST_ARB:  w_state_nxt = w_pick_any ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (w_beat_acc && bus.beat_last) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_beat_acc && r_to_cnt == TO_W'(TO_MAX-1)) begin
          w_to_hit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_started   <= 1'b0;
      r_grant     <= '0;
      r_grant_cls <= '0;
      r_rr_ptr    <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
      case (r_state)
        ST_ARB: begin
          r_grant     <= w_pick_oh;
          r_grant_cls <= r_cls;
          r_to_cnt    <= '0;
          if (w_pick_any) r_rr_ptr <= w_ptr_nxt;
        end
        ST_HOLD: begin
          if (w_beat_acc)            r_to_cnt <= '0;
          else if (r_to_cnt != '1)   r_to_cnt <= r_to_cnt + 1'b1;
          if (w_state_nxt == ST_IDLE) begin
            r_grant     <= '0;
            r_grant_cls <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Decision payload is only meaningful once captured, so it carries no reset
  always_ff @(posedge clk) begin
    if (w_dec_acc) begin
      r_req <= bus.dec_req;
      r_cls <= bus.dec_cls;
    end
  end

  assign bus.dec_ready   = w_dec_rdy;
  assign bus.beat_ready  = w_beat_rdy;
  assign bus.grant       = r_grant;
  assign bus.grant_cls   = r_grant_cls;
  assign bus.timeout_evt = w_to_hit;
endmodule

// File: tb/tb_route_grant_sequencer.sv
// Directed and randomized bench for route_grant_sequencer with a round-robin
// reference model over a plain pointer and request vector.
module tb_route_grant_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_ptr  = 0;

  route_grant_sequencer_if #(.NPORT(4)) bus ();

  route_grant_sequencer #(.NPORT(4), .TO_W(8), .TO_MAX(200)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // First requesting port scanning upward from ptr, wrapping; -1 if none
  function automatic int model_pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic issue(input logic [3:0] req, input logic [1:0] cls, output logic [3:0] g);
    int t = 0;
    int idx;
    while (!bus.dec_ready && t < 20) begin tick; t++; end
    chk("dec_ready_wait", bus.dec_ready, 1);
    bus.dec_valid = 1'b1;
    bus.dec_req   = req;
    bus.dec_cls   = cls;
    tick;
    bus.dec_valid = 1'b0;
    idx = model_pick(req, m_ptr);
    g   = '0;
    if (idx < 0) begin
      chk("drop_grant", bus.grant, 0);
      chk("drop_dec_ready", bus.dec_ready, 1);
    end else begin
      g[idx] = 1'b1;
      m_ptr  = (idx + 1) % 4;
      chk("arb_grant_zero", bus.grant, 0);
      chk("arb_dec_ready", bus.dec_ready, 0);
      tick;
      chk("grant", bus.grant, g);
      chk("grant_cls", bus.grant_cls, cls);
    end
  endtask

  task automatic run_packet(input int nbeats, input logic [3:0] g, input int stall_at,
                            input int stall_len, input bit rnd);
    int   b = 0, cyc = 0, evt = 0;
    logic stall, acc;
    logic [3:0] pr;
    while (b < nbeats && cyc < 200) begin
      stall = (cyc >= stall_at && cyc < stall_at + stall_len) || (rnd && $urandom_range(3) == 0);
      pr    = 4'($urandom);
      pr    = stall ? (pr & ~g) : (pr | g);
      bus.port_ready = pr;
      bus.beat_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
      bus.beat_last  = (b == nbeats - 1);
      #1;
      chk("beat_ready", bus.beat_ready, !stall);
      chk("grant_held", bus.grant, g);
      if (bus.timeout_evt) evt++;
      acc = bus.beat_valid && !stall;
      tick;
      if (acc) b++;
      cyc++;
    end
    bus.beat_valid = 1'b0;
    bus.beat_last  = 1'b0;
    bus.port_ready = 4'hF;
    chk("beats_taken", b, nbeats);
    chk("release_grant", bus.grant, 0);
    chk("release_dec_ready", bus.dec_ready, 1);
    chk("pkt_no_timeout", evt, 0);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_ptr = 0;
    tick;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    int k;
    rst_n          = 1'b0;
    bus.dec_valid  = 1'b1;
    bus.dec_req    = 4'b1010;
    bus.dec_cls    = 2'd3;
    bus.beat_valid = 1'b0;
    bus.beat_last  = 1'b0;
    bus.port_ready = 4'hF;

    // Reset with a pending decision
    repeat (3) tick;
    chk("rst_grant", bus.grant, 0);
    chk("rst_dec_ready", bus.dec_ready, 0);
    chk("rst_timeout", bus.timeout_evt, 0);
    chk("rst_grant_cls", bus.grant_cls, 0);
    #2 rst_n = 1'b1;
    #1 chk("dec_ready_before_clk", bus.dec_ready, 0);
    tick;
    chk("dec_ready_after_clk", bus.dec_ready, 1);
    issue(4'b1010, 2'd1, g);
    run_packet(1, g, 100, 0, 1'b0);
    issue(4'b1111, 2'd2, g);
    run_packet(1, g, 100, 0, 1'b0);

    // Round-robin sweep and wrap from a fresh pointer
    apply_reset;
    for (int i = 0; i < 5; i++) begin
      issue(4'b1111, 2'(i), g);
      run_packet(1, g, 100, 0, 1'b0);
    end

    // Backpressure mid-packet
    issue(4'b0100, 2'd2, g);
    run_packet(3, g, 1, 5, 1'b0);

    // Stall timeout: beats offered only while the granted port is busy
    issue(4'b1001, 2'd1, g);
    k = 0;
    while (k < 300) begin
      bus.beat_valid = 1'($urandom_range(1));
      bus.port_ready = 4'($urandom) & ~g;
      #1;
      if (bus.timeout_evt) break;
      tick;
      k++;
    end
    chk("timeout_cycle", k, 199);
    chk("timeout_grant_live", bus.grant, g);
    tick;
    bus.beat_valid = 1'b0;
    bus.port_ready = 4'hF;
    chk("timeout_grant_clr", bus.grant, 0);
    chk("timeout_dec_ready", bus.dec_ready, 1);
    chk("timeout_single_pulse", bus.timeout_evt, 0);

    // Tail beat on the terminal count wins over the timeout
    issue(4'b0110, 2'd3, g);
    repeat (199) tick;
    bus.beat_valid = 1'b1;
    bus.beat_last  = 1'b1;
    #1;
    chk("tail_tc_beat_ready", bus.beat_ready, 1);
    chk("tail_tc_no_timeout", bus.timeout_evt, 0);
    tick;
    bus.beat_valid = 1'b0;
    bus.beat_last  = 1'b0;
    chk("tail_tc_release", bus.grant, 0);
    chk("tail_tc_after", bus.timeout_evt, 0);

    // Empty request dropped; beats in IDLE ignored
    issue(4'b0000, 2'd1, g);
    bus.beat_valid = 1'b1;
    #1 chk("idle_beat_ready", bus.beat_ready, 0);
    bus.beat_valid = 1'b0;
    issue(4'b1111, 2'd0, g);
    run_packet(2, g, 100, 0, 1'b0);

    // Asynchronous reset during HOLD
    issue(4'b1111, 2'd2, g);
    tick;
    bus.beat_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", bus.grant, 0);
    chk("async_rst_beat_ready", bus.beat_ready, 0);
    #3 rst_n = 1'b1;
    m_ptr = 0;
    bus.beat_valid = 1'b0;
    #1 chk("async_rel_dec_ready", bus.dec_ready, 0);
    tick;
    chk("async_idle_dec_ready", bus.dec_ready, 1);
    chk("async_idle_grant", bus.grant, 0);
    issue(4'b1111, 2'd1, g);
    run_packet(1, g, 100, 0, 1'b0);

    // Randomized decisions and packets
    for (int i = 0; i < 30; i++) begin
      issue(4'($urandom), 2'($urandom), g);
      if (g != 4'b0000) run_packet(int'($urandom_range(4, 1)), g, 100, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
